// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// ALU operations, datapath mux selects and the decoded opcode/funct values.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EX_R  = 4'd2,
        S_EX_I  = 4'd3,
        S_MA    = 4'd4,
        S_MRD   = 4'd5,
        S_MWR   = 4'd6,
        S_WB_R  = 4'd7,
        S_WB_I  = 4'd8,
        S_WB_LW = 4'd9,
        S_BR    = 4'd10,
        S_JMP   = 4'd11,
        S_JAL   = 4'd12,
        S_JR    = 4'd13
    } state_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] IMM_SIGN = 2'b00;
    localparam logic [1:0] IMM_ZERO = 2'b01;
    localparam logic [1:0] IMM_HI   = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mcpu_alu_dec.sv
// Combinational ALU/extender decode: R-type funct -> ALU op, and I-type
// opcode -> ALU op plus immediate-extender mode, each with a legality flag.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] r_alu_ctrl,
    output logic       r_legal,
    output logic [2:0] i_alu_ctrl,
    output logic [1:0] i_imm_sel,
    output logic       i_legal
);

    always_comb begin
        r_alu_ctrl = ALU_AND;
        r_legal    = 1'b1;
        case (funct)
            FN_ADD:  r_alu_ctrl = ALU_ADD;
            FN_SUB:  r_alu_ctrl = ALU_SUB;
            FN_AND:  r_alu_ctrl = ALU_AND;
            FN_OR:   r_alu_ctrl = ALU_OR;
            FN_NOR:  r_alu_ctrl = ALU_NOR;
            FN_SLT:  r_alu_ctrl = ALU_SLT;
            default: r_legal    = 1'b0;
        endcase
    end

    always_comb begin
        i_alu_ctrl = ALU_AND;
        i_imm_sel  = IMM_SIGN;
        i_legal    = 1'b1;
        case (opcode)
            OP_ADDI: begin i_alu_ctrl = ALU_ADD; i_imm_sel = IMM_SIGN; end
            OP_ANDI: begin i_alu_ctrl = ALU_AND; i_imm_sel = IMM_ZERO; end
            OP_ORI:  begin i_alu_ctrl = ALU_OR;  i_imm_sel = IMM_ZERO; end
            OP_SLTI: begin i_alu_ctrl = ALU_SLT; i_imm_sel = IMM_SIGN; end
            OP_LUI:  begin i_alu_ctrl = ALU_LUI; i_imm_sel = IMM_HI;   end
            default: i_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// write-back and drives every datapath select and write enable.
module mcpu_ctrl
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mio_ready,
    output logic       pc_we,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_sel,
    output logic [1:0] pc_source,
    output logic [3:0] state
);

    state_e state_q, state_d;

    logic [2:0] r_alu_ctrl, i_alu_ctrl;
    logic [1:0] i_imm_sel;
    logic       r_legal, i_legal;

    logic pc_we_c, mem_write_c, ir_write_c, reg_write_c;

    mcpu_alu_dec u_alu_dec (
        .opcode     (opcode),
        .funct      (funct),
        .r_alu_ctrl (r_alu_ctrl),
        .r_legal    (r_legal),
        .i_alu_ctrl (i_alu_ctrl),
        .i_imm_sel  (i_imm_sel),
        .i_legal    (i_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_we_c     = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        reg_dst     = DST_RT;
        mem_to_reg  = WD_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        alu_ctrl    = ALU_AND;
        imm_sel     = IMM_SIGN;
        pc_source   = PCS_ALU;

        case (state_q)
            S_IF: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_ctrl   = ALU_ADD;
                pc_source  = PCS_ALU;
                ir_write_c = mio_ready;
                pc_we_c    = mio_ready;
                if (mio_ready) state_d = S_ID;
            end
            S_ID: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = SRCB_IMM_SH2;
                alu_ctrl  = ALU_ADD;
                imm_sel   = IMM_SIGN;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) state_d = S_JR;
                        else if (r_legal)   state_d = S_EX_R;
                        else                state_d = S_IF;
                    end
                    OP_LW, OP_SW:   state_d = S_MA;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_JMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = i_legal ? S_EX_I : S_IF;
                endcase
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = r_alu_ctrl;
                state_d   = S_WB_R;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = i_alu_ctrl;
                imm_sel   = i_imm_sel;
                state_d   = S_WB_I;
            end
            S_MA: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                imm_sel   = IMM_SIGN;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mio_ready) state_d = S_WB_LW;
            end
            S_MWR: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
                if (mio_ready) state_d = S_IF;
            end
            S_WB_R: begin
                reg_write_c = 1'b1;
                reg_dst     = DST_RD;
                mem_to_reg  = WD_ALUOUT;
                state_d     = S_IF;
            end
            S_WB_I: begin
                reg_write_c = 1'b1;
                reg_dst     = DST_RT;
                mem_to_reg  = WD_ALUOUT;
                state_d     = S_IF;
            end
            S_WB_LW: begin
                reg_write_c = 1'b1;
                reg_dst     = DST_RT;
                mem_to_reg  = WD_MDR;
                state_d     = S_IF;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = ALU_SUB;
                pc_source = PCS_ALUOUT;
                pc_we_c   = zero ^ (opcode == OP_BNE);
                state_d   = S_IF;
            end
            S_JMP: begin
                pc_we_c   = 1'b1;
                pc_source = PCS_JUMP;
                state_d   = S_IF;
            end
            S_JAL: begin
                pc_we_c     = 1'b1;
                pc_source   = PCS_JUMP;
                reg_write_c = 1'b1;
                reg_dst     = DST_RA;
                mem_to_reg  = WD_PC;
                state_d     = S_IF;
            end
            S_JR: begin
                pc_we_c   = 1'b1;
                pc_source = PCS_RS;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Architectural writes are masked combinationally so none can slip through while reset is low.
    assign pc_we     = pc_we_c     & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign state     = state_q;

endmodule
